// File: rtl/logic_unit_pkg.sv
// Shared definitions for the pipelined logic unit: op codes and the per-bit gate function.
package logic_unit_pkg;

  typedef enum logic [2:0] {
    OP_AND  = 3'd0,
    OP_OR   = 3'd1,
    OP_NAND = 3'd2,
    OP_NOR  = 3'd3,
    OP_XOR  = 3'd4,
    OP_XNOR = 3'd5,
    OP_NOTA = 3'd6,
    OP_BUFA = 3'd7
  } op_e;

  localparam int OP_W = 3;

  // Evaluated per bit so the top can apply it to any operand width.
  function automatic logic lu_bit(input logic a, input logic b, input op_e op);
    logic r;
    r = 1'b0;
    case (op)
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_NAND: r = ~(a & b);
      OP_NOR:  r = ~(a | b);
      OP_XOR:  r = a ^ b;
      OP_XNOR: r = ~(a ^ b);
      OP_NOTA: r = ~a;
      OP_BUFA: r = a;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/logic_unit_stage.sv
// One valid/payload register slice; loads when the surrounding chain says it may.
module logic_unit_stage #(
  parameter int PW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic          d_valid,
  input  logic [PW-1:0] d_data,
  output logic          valid,
  output logic [PW-1:0] data
);

  // Payload is cleared too so the visible result reads zero straight out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (load) begin
      valid <= d_valid;
      data  <= d_data;
    end
  end

endmodule

// File: rtl/logic_unit_pipe.sv
// Pipelined bitwise logic unit with valid/ready flow control and a delivered-result counter.
// Optional zero/parity flags are built when LOGIC_UNIT_FLAGS_EN is defined.
module logic_unit_pipe
  import logic_unit_pkg::*;
#(
  parameter int WIDTH  = 4,
  parameter int STAGES = 2,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [2:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_y,
  output logic [2:0]       out_op,
`ifdef LOGIC_UNIT_FLAGS_EN
  output logic             out_zero,
  output logic             out_parity,
`endif
  output logic [CNT_W-1:0] res_count
);

`ifdef LOGIC_UNIT_FLAGS_EN
  localparam int PW = WIDTH + OP_W + 2;
`else
  localparam int PW = WIDTH + OP_W;
`endif

  logic [WIDTH-1:0] y_p0;
  logic [PW-1:0]    dat_p [STAGES+1];
  logic [STAGES:0]  vld_p;
  logic [STAGES-1:0] load;

  // Stage 0: combinational gate evaluation feeding the first register slice
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign y_p0[i] = lu_bit(in_a[i], in_b[i], op_e'(in_op));
  end

  assign vld_p[0] = in_valid;
`ifdef LOGIC_UNIT_FLAGS_EN
  assign dat_p[0] = {^y_p0, ~|y_p0, in_op, y_p0};
`else
  assign dat_p[0] = {in_op, y_p0};
`endif

  // A stage may load when it is empty or when everything downstream is moving.
  always_comb begin
    logic nxt;
    load = '0;
    nxt  = out_ready;
    for (int k = STAGES - 1; k >= 0; k--) begin
      load[k] = !vld_p[k+1] || nxt;
      nxt     = load[k];
    end
  end

  assign in_ready = load[0];

  // Stages 1..STAGES: registered slices
  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic_unit_stage #(.PW(PW)) u_stage (
      .clk     (clk),
      .rst     (rst),
      .load    (load[k]),
      .d_valid (vld_p[k]),
      .d_data  (dat_p[k]),
      .valid   (vld_p[k+1]),
      .data    (dat_p[k+1])
    );
  end

  assign out_valid  = vld_p[STAGES];
  assign out_y      = dat_p[STAGES][WIDTH-1:0];
  assign out_op     = dat_p[STAGES][WIDTH+OP_W-1:WIDTH];
`ifdef LOGIC_UNIT_FLAGS_EN
  assign out_zero   = dat_p[STAGES][WIDTH+OP_W];
  assign out_parity = dat_p[STAGES][WIDTH+OP_W+1];
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_count <= '0;
    end else if (out_valid && out_ready) begin
      res_count <= res_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Bench for logic_unit_pipe: queue-based reference model, directed and random scenarios.
module tb_logic_unit_pipe;
  localparam int WIDTH  = 4;
  localparam int STAGES = 2;
  localparam int CNT_W  = 3;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_a = '0;
  logic [WIDTH-1:0] in_b = '0;
  logic [2:0]       in_op = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] out_y;
  logic [2:0]       out_op;
  logic [CNT_W-1:0] res_count;
`ifdef LOGIC_UNIT_FLAGS_EN
  logic             out_zero;
  logic             out_parity;
`endif

  logic_unit_pipe #(.WIDTH(WIDTH), .STAGES(STAGES), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_op      (in_op),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_y      (out_y),
    .out_op     (out_op),
`ifdef LOGIC_UNIT_FLAGS_EN
    .out_zero   (out_zero),
    .out_parity (out_parity),
`endif
    .res_count  (res_count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: beats in flight as {op, y}; count of delivered results.
  logic [WIDTH+2:0] exp_q[$];
  int               cnt_mdl = 0;

  // Values sampled on the falling edge before each rising edge.
  bit               s_ir, s_ov, s_or, oxfer, m_ir, m_has;
  logic [WIDTH-1:0] s_y;
  logic [2:0]       s_op;
  logic [WIDTH+2:0] m_front;
`ifdef LOGIC_UNIT_FLAGS_EN
  bit               s_zero, s_par;
`endif

  function automatic logic [WIDTH-1:0] ref_y(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                             input logic [2:0] op);
    case (op)
      3'd0: return a & b;
      3'd1: return a | b;
      3'd2: return ~(a & b);
      3'd3: return ~(a | b);
      3'd4: return a ^ b;
      3'd5: return ~(a ^ b);
      3'd6: return ~a;
      default: return a;
    endcase
  endfunction

  task automatic tick();
    @(negedge clk);
    s_ir = in_ready; s_ov = out_valid; s_or = out_ready; s_y = out_y; s_op = out_op;
`ifdef LOGIC_UNIT_FLAGS_EN
    s_zero = out_zero; s_par = out_parity;
`endif
    // Only a completely full pipe with a stalled consumer refuses input.
    m_ir    = (exp_q.size() < STAGES) || out_ready;
    oxfer   = s_ov && s_or;
    m_has   = 1'b0;
    m_front = '0;
    if (oxfer) begin
      if (exp_q.size() > 0) begin
        m_front = exp_q.pop_front();
        m_has   = 1'b1;
      end
      cnt_mdl = (cnt_mdl + 1) % (1 << CNT_W);
    end
    if (in_valid && s_ir) exp_q.push_back({in_op, ref_y(in_a, in_b, in_op)});
    @(posedge clk);
    #1;
  endtask

  task automatic rand_beat();
    in_a  = WIDTH'($urandom);
    in_b  = WIDTH'($urandom);
    in_op = 3'($urandom);
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp += 4;
    if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    if (out_y !== '0) begin n_bad++; $display("FAIL reset_out_y got=%b exp=0000", out_y); end
    if (out_op !== '0) begin n_bad++; $display("FAIL reset_out_op got=%0d exp=0", out_op); end
    if (res_count !== '0) begin n_bad++; $display("FAIL reset_res_count got=%0d exp=0", res_count); end
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete(); cnt_mdl = 0;
    @(posedge clk);
    #1;
    n_cmp++;
    if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
  endtask

  task automatic test_ops_directed();
    logic [WIDTH-1:0] tab [8];
    int nout;
    tab = '{4'b1000, 4'b1110, 4'b0111, 4'b0001, 4'b0110, 4'b1001, 4'b0011, 4'b1100};
    nout = 0;
    out_ready = 1'b1;
    for (int t = 0; t < 8 + STAGES + 2; t++) begin
      in_valid = (t < 8);
      in_a = 4'b1100; in_b = 4'b1010; in_op = 3'(t);
      tick();
      if (oxfer) begin
        n_cmp += 3;
        if (!m_has || {s_op, s_y} !== m_front) begin
          n_bad++; $display("FAIL ops_model got op=%0d y=%b exp=%b", s_op, s_y, m_front);
        end
        if (nout < 8 && (s_y !== tab[nout] || s_op !== 3'(nout))) begin
          n_bad++; $display("FAIL ops_table got op=%0d y=%b exp op=%0d y=%b", s_op, s_y, nout, tab[nout]);
        end
        if (t != nout + STAGES) begin
          n_bad++; $display("FAIL ops_latency got cycle=%0d exp=%0d", t, nout + STAGES);
        end
        nout++;
      end
    end
    n_cmp += 2;
    if (nout != 8) begin n_bad++; $display("FAIL ops_count got=%0d exp=8", nout); end
    if (res_count !== CNT_W'(cnt_mdl)) begin
      n_bad++; $display("FAIL ops_res_count got=%0d exp=%0d", res_count, cnt_mdl);
    end
    in_valid = 1'b0;
  endtask

  task automatic test_stall();
    bit               p_stall;
    logic [WIDTH-1:0] p_y;
    logic [2:0]       p_op;
    p_stall = 1'b0; p_y = '0; p_op = '0;
    for (int t = 0; t < 30; t++) begin
      in_valid  = (t < 12);
      out_ready = (t >= 5);
      rand_beat();
      tick();
      n_cmp++;
      if (s_ir !== m_ir) begin n_bad++; $display("FAIL stall_in_ready t=%0d got=%b exp=%b", t, s_ir, m_ir); end
      if (t == 4) begin
        n_cmp++;
        if (s_ir !== 1'b0) begin n_bad++; $display("FAIL stall_full got in_ready=%b exp=0", s_ir); end
      end
      if (p_stall && s_ov) begin
        n_cmp++;
        if (s_y !== p_y || s_op !== p_op) begin
          n_bad++; $display("FAIL stall_hold got op=%0d y=%b exp op=%0d y=%b", s_op, s_y, p_op, p_y);
        end
      end
      p_stall = s_ov && !s_or; p_y = s_y; p_op = s_op;
      if (oxfer) begin
        n_cmp++;
        if (!m_has || {s_op, s_y} !== m_front) begin
          n_bad++; $display("FAIL stall_out got op=%0d y=%b exp=%b", s_op, s_y, m_front);
        end
      end
    end
    n_cmp++;
    if (exp_q.size() != 0) begin n_bad++; $display("FAIL stall_drain left=%0d exp=0", exp_q.size()); end
  endtask

  task automatic test_toggle();
    for (int t = 0; t < 40; t++) begin
      in_valid  = (t < 24);
      out_ready = (t >= 24) ? 1'b1 : t[0];
      rand_beat();
      tick();
      n_cmp++;
      if (s_ir !== m_ir) begin n_bad++; $display("FAIL toggle_in_ready got=%b exp=%b", s_ir, m_ir); end
      if (oxfer) begin
        n_cmp++;
        if (!m_has || {s_op, s_y} !== m_front) begin
          n_bad++; $display("FAIL toggle_out got op=%0d y=%b exp=%b", s_op, s_y, m_front);
        end
      end
    end
    n_cmp += 2;
    if (exp_q.size() != 0) begin n_bad++; $display("FAIL toggle_drain left=%0d exp=0", exp_q.size()); end
    if (res_count !== CNT_W'(cnt_mdl)) begin
      n_bad++; $display("FAIL toggle_res_count got=%0d exp=%0d", res_count, cnt_mdl);
    end
  endtask

  task automatic test_random();
    bit               p_stall;
    logic [WIDTH-1:0] p_y;
    logic [2:0]       p_op;
    p_stall = 1'b0; p_y = '0; p_op = '0;
    for (int t = 0; t < 200; t++) begin
      in_valid  = (t < 180) && ($urandom_range(3) != 0);
      out_ready = (t >= 180) || ($urandom_range(2) != 0);
      rand_beat();
      tick();
      n_cmp++;
      if (s_ir !== m_ir) begin n_bad++; $display("FAIL rand_in_ready t=%0d got=%b exp=%b", t, s_ir, m_ir); end
      if (p_stall) begin
        n_cmp++;
        if (!s_ov || s_y !== p_y || s_op !== p_op) begin
          n_bad++; $display("FAIL rand_hold got v=%b op=%0d y=%b exp op=%0d y=%b", s_ov, s_op, s_y, p_op, p_y);
        end
      end
      p_stall = s_ov && !s_or; p_y = s_y; p_op = s_op;
      if (oxfer) begin
        n_cmp++;
        if (!m_has || {s_op, s_y} !== m_front) begin
          n_bad++; $display("FAIL rand_out got op=%0d y=%b exp=%b", s_op, s_y, m_front);
        end
      end
    end
    n_cmp += 2;
    if (exp_q.size() != 0) begin n_bad++; $display("FAIL rand_drain left=%0d exp=0", exp_q.size()); end
    if (res_count !== CNT_W'(cnt_mdl)) begin
      n_bad++; $display("FAIL rand_res_count got=%0d exp=%0d", res_count, cnt_mdl);
    end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int t = 0; t < 2; t++) begin
      rand_beat();
      tick();
    end
    in_valid = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b1) begin n_bad++; $display("FAIL rmid_preload got out_valid=%b exp=1", out_valid); end
    #2 rst = 1'b1;
    #1;
    exp_q.delete(); cnt_mdl = 0;
    n_cmp += 3;
    if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rmid_out_valid got=%b exp=0", out_valid); end
    if (out_y !== '0) begin n_bad++; $display("FAIL rmid_out_y got=%b exp=0000", out_y); end
    if (res_count !== '0) begin n_bad++; $display("FAIL rmid_res_count got=%0d exp=0", res_count); end
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    for (int t = 0; t < 6; t++) begin
      tick();
      n_cmp++;
      if (s_ov !== 1'b0 || s_ir !== 1'b1) begin
        n_bad++; $display("FAIL rmid_ghost got out_valid=%b in_ready=%b exp 0/1", s_ov, s_ir);
      end
    end
  endtask

  task automatic test_wrap();
    bit seen_wrap;
    logic [CNT_W-1:0] prev;
    seen_wrap = 1'b0;
    prev = res_count;
    out_ready = 1'b1;
    for (int t = 0; t < 9 + STAGES + 3; t++) begin
      in_valid = (t < 9);
      rand_beat();
      tick();
      n_cmp++;
      if (res_count !== CNT_W'(cnt_mdl)) begin
        n_bad++; $display("FAIL wrap_step got=%0d exp=%0d", res_count, cnt_mdl);
      end
      if (prev == '1 && res_count == '0) seen_wrap = 1'b1;
      prev = res_count;
    end
    n_cmp += 2;
    if (res_count !== CNT_W'(1)) begin n_bad++; $display("FAIL wrap_final got=%0d exp=1", res_count); end
    if (!seen_wrap) begin n_bad++; $display("FAIL wrap_seen got=0 exp=1"); end
  endtask

`ifdef LOGIC_UNIT_FLAGS_EN
  task automatic test_flags();
    logic [2:0] ops [2];
    int nout;
    ops = '{3'd4, 3'd0};
    nout = 0;
    out_ready = 1'b1;
    for (int t = 0; t < 2 + STAGES + 2; t++) begin
      in_valid = (t < 2);
      in_a = 4'b1010; in_b = 4'b1010; in_op = ops[t % 2];
      tick();
      if (oxfer) begin
        n_cmp++;
        if (s_zero !== (s_y == '0) || s_par !== ^s_y || !m_has || {s_op, s_y} !== m_front) begin
          n_bad++; $display("FAIL flags got y=%b z=%b p=%b exp=%b", s_y, s_zero, s_par, m_front);
        end
        n_cmp++;
        if (nout == 0 && (s_y !== 4'b0000 || s_zero !== 1'b1 || s_par !== 1'b0)) begin
          n_bad++; $display("FAIL flags_xor got y=%b z=%b p=%b exp 0000/1/0", s_y, s_zero, s_par);
        end else if (nout == 1 && (s_y !== 4'b1010 || s_zero !== 1'b0 || s_par !== 1'b0)) begin
          n_bad++; $display("FAIL flags_and got y=%b z=%b p=%b exp 1010/0/0", s_y, s_zero, s_par);
        end
        nout++;
      end
    end
    n_cmp++;
    if (nout != 2) begin n_bad++; $display("FAIL flags_count got=%0d exp=2", nout); end
  endtask
`endif

  initial begin
    test_reset();
    test_ops_directed();
    test_stall();
    test_toggle();
    test_random();
    test_reset_mid();
    test_wrap();
`ifdef LOGIC_UNIT_FLAGS_EN
    test_flags();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
